sr_input_debouncer: RTL and testbench

- Upstream conditioning stage for the set/reset D flip-flop pair.
- Takes two raw, asynchronous, bouncy push-button inputs (set and reset).
- Synchronizes and debounces each one.
- Emits clean single-cycle, mutually exclusive s/r pulses plus debounced levels, all registered on clk and directly connectable to the flip-flop's s and r inputs.

---
 rtl/sr_input_pkg.sv | 16 +
 rtl/sr_input_debouncer_debounce_channel.sv | 58 +++++
 rtl/sr_input_debouncer.sv | 61 ++++++
 tb/tb_sr_input_debouncer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_input_pkg.sv
// rtl/sr_input_pkg.sv - shared encodings and defaults for the set/reset input debouncer
package sr_input_pkg;

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_CNT_W           = 5;
    localparam int DEBOUNCE_MIN            = 2;

    // Upper bound keeps the terminal count representable in the counter.
    function automatic bit debounce_cfg_ok(input int cycles, input int cnt_w);
        return (cycles >= DEBOUNCE_MIN) && (cycles <= (1 << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/sr_input_debouncer_debounce_channel.sv
// rtl/sr_input_debouncer_debounce_channel.sv - 2-flop synchronizer plus LOW/HIGH debounce FSM for one button
module debounce_channel
    import sr_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             toward;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= ST_LOW;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // rise is combinational so the top registers the pulse on the same edge the level flips.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise      = 1'b0;
        toward    = (state == ST_LOW) ? sync2 : ~sync2;
        if (!toward) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            state_nxt = ~state;
            cnt_nxt   = '0;
            rise      = (state == ST_LOW);
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    assign level = (state == ST_HIGH);

endmodule

// File: rtl/sr_input_debouncer.sv
// rtl/sr_input_debouncer.sv - debounced, mutually exclusive set/reset pulse generator
module sr_input_debouncer
    import sr_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic s_pulse,
    output logic r_pulse,
    output logic set_level,
    output logic rst_level,
    output logic collision
);

    logic set_rise;
    logic rst_rise;

    if (!debounce_cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
        $error("sr_input_debouncer: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_set),
        .level (set_level),
        .rise  (set_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_rst),
        .level (rst_level),
        .rise  (rst_rise)
    );

    // Reset wins a same-edge tie so the flip-flop never sees s and r together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pulse   <= 1'b0;
            r_pulse   <= 1'b0;
            collision <= 1'b0;
        end else begin
            s_pulse   <= set_rise & ~rst_rise;
            r_pulse   <= rst_rise;
            collision <= set_rise & rst_rise;
        end
    end

endmodule

// File: tb/tb_sr_input_debouncer.sv
// tb/tb_sr_input_debouncer.sv - directed self-checking bench for sr_input_debouncer
module tb_sr_input_debouncer;

    logic clk;
    logic rst_n;
    logic btn_set;
    logic btn_rst;
    logic s_pulse;
    logic r_pulse;
    logic set_level;
    logic rst_level;
    logic collision;

    int checks;
    int failures;

    sr_input_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_set   (btn_set),
        .btn_rst   (btn_rst),
        .s_pulse   (s_pulse),
        .r_pulse   (r_pulse),
        .set_level (set_level),
        .rst_level (rst_level),
        .collision (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_set = 1'b0;
        btn_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_pulse, r_pulse, set_level, rst_level, collision} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold outputs=%b expected=00000",
                     {s_pulse, r_pulse, set_level, rst_level, collision});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if ({s_pulse, r_pulse, set_level, rst_level, collision} !== 5'b0) begin
                failures++;
                $display("FAIL idle cycle=%0d outputs=%b expected=00000", k,
                         {s_pulse, r_pulse, set_level, rst_level, collision});
            end
        end
    endtask

    task automatic test_clean_press();
        btn_set = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (s_pulse !== (k == 5) || set_level !== (k >= 5) || r_pulse !== 1'b0) begin
                failures++;
                $display("FAIL clean_press edge=E%0d s_pulse=%b set_level=%b r_pulse=%b expected=%b/%b/0",
                         k, s_pulse, set_level, r_pulse, (k == 5), (k >= 5));
            end
        end
        btn_set = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (set_level !== (k < 5) || s_pulse !== 1'b0) begin
                failures++;
                $display("FAIL clean_release edge=E%0d set_level=%b s_pulse=%b expected=%b/0",
                         k, set_level, s_pulse, (k < 5));
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern;
        pattern = 8'b1110_1101;
        for (int k = 0; k < 30; k++) begin
            btn_rst = (k < 8) ? pattern[k] : 1'b1;
            tick();
            checks++;
            if (r_pulse !== (k == 10) || rst_level !== (k >= 10) || s_pulse !== 1'b0 || collision !== 1'b0) begin
                failures++;
                $display("FAIL bounce edge=E%0d r_pulse=%b rst_level=%b s_pulse=%b collision=%b expected=%b/%b/0/0",
                         k, r_pulse, rst_level, s_pulse, collision, (k == 10), (k >= 10));
            end
        end
        btn_rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (rst_level !== 1'b0) begin
            failures++;
            $display("FAIL bounce_release rst_level=%b expected=0", rst_level);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 25; k++) begin
            btn_set = (k < 18) && ((k % 6) < 3);
            tick();
            checks++;
            if (s_pulse !== 1'b0 || set_level !== 1'b0) begin
                failures++;
                $display("FAIL glitch edge=E%0d s_pulse=%b set_level=%b expected=0/0",
                         k, s_pulse, set_level);
            end
        end
        btn_set = 1'b0;
    endtask

    task automatic test_repress();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 35; k++) begin
            btn_set = (k < 10) || (k >= 20);
            tick();
            if (s_pulse === 1'b1) pulses++;
            checks++;
            if (s_pulse !== (k == 5 || k == 25) ||
                set_level !== ((k >= 5 && k < 15) || k >= 25)) begin
                failures++;
                $display("FAIL repress edge=E%0d s_pulse=%b set_level=%b expected=%b/%b",
                         k, s_pulse, set_level, (k == 5 || k == 25),
                         ((k >= 5 && k < 15) || k >= 25));
            end
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL repress_count pulses=%0d expected=2", pulses);
        end
        btn_set = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_coincidence();
        btn_set = 1'b1;
        btn_rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (r_pulse !== (k == 5) || s_pulse !== 1'b0 || collision !== (k == 5) ||
                set_level !== (k >= 5) || rst_level !== (k >= 5)) begin
                failures++;
                $display("FAIL coincidence edge=E%0d r=%b s=%b col=%b sl=%b rl=%b expected=%b/0/%b/%b/%b",
                         k, r_pulse, s_pulse, collision, set_level, rst_level,
                         (k == 5), (k == 5), (k >= 5), (k >= 5));
            end
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_press();
        btn_set = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({s_pulse, r_pulse, set_level, rst_level, collision} !== 5'b0) begin
                failures++;
                $display("FAIL mid_reset sample=%0d outputs=%b expected=00000", k,
                         {s_pulse, r_pulse, set_level, rst_level, collision});
            end
            if (k < 2) tick();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (s_pulse !== (k == 5) || set_level !== (k >= 5) || r_pulse !== 1'b0) begin
                failures++;
                $display("FAIL post_reset edge=G%0d s_pulse=%b set_level=%b r_pulse=%b expected=%b/%b/0",
                         k, s_pulse, set_level, r_pulse, (k == 5), (k >= 5));
            end
        end
        btn_set = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_set  = 1'b0;
        btn_rst  = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_repress();
        test_coincidence();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
